uart_tx_fifo_cfg: RTL and testbench

Parametrised UART transmitter. It replaces the fixed 8N1, single-byte transmitter with a configurable frame: data width, runtime parity (none/even/odd) and 1 or 2 stop bits. A small input FIFO with a valid/ready handshake lets the producer queue bytes, and frames are sent back-to-back with no idle gap. It sits between the system-side byte producer and the tx pin, and takes the shared baud generator's 1x `tick` (one bit period per tick).

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_sync_fifo.sv | 68 ++++++
 rtl/uart_tx_fifo_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: state encoding, limits and parity helper.
package uart_pkg;

  // Widest data field any UART block in this family supports.
  localparam int UART_MAX_DATA_BITS = 9;

  // Transmit FSM state encoding (fixed values so encodings stay stable across revisions).
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Parity over a zero-extended data word; odd=1 inverts the even-parity result.
  function automatic logic uart_parity(
    input logic [UART_MAX_DATA_BITS-1:0] data,
    input logic                          odd
  );
    uart_parity = (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes while full and pops while
// empty are ignored; a simultaneous push and pop leaves the level unchanged.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_ZERO = LW'(0);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO   = AW'(0);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (level_r == LEVEL_FULL);
  assign empty     = (level_r == LEVEL_ZERO);
  assign level     = level_r;
  assign rdata     = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array; no reset needed since entries are only read after a push.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers (power-of-two depth lets them wrap naturally) and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LEVEL_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LEVEL_ONE;
        2'b01:   level_r <= level_r - LEVEL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with input FIFO and per-frame configuration (parity
// none/even/odd, one or two stop bits). Frames go out LSB first, back to back,
// advancing one line bit per baud tick.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            tick,
  input  logic [DATA_BITS-1:0]            s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            cfg_parity_en,
  input  logic                            cfg_parity_odd,
  input  logic                            cfg_two_stop,
  output logic                            tx,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam logic [3:0] LAST_BIT_CNT = 4'(DATA_BITS);

  logic [DATA_BITS-1:0]          fifo_rdata_s;
  logic                          fifo_full_s;
  logic                          fifo_empty_s;
  logic                          pop_s;
  logic                          frame_end_s;
  logic [UART_MAX_DATA_BITS-1:0] par_data_s;

  uart_state_t                   state_r;
  logic [DATA_BITS-1:0]          shift_r;
  logic [3:0]                    bit_cnt_r;
  logic                          stop_cnt_r;
  logic                          par_en_r;
  logic                          two_stop_r;
  logic                          par_bit_r;
  logic                          tx_r;
  logic                          busy_r;
  logic                          done_r;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (pop_s),
    .wdata (s_data),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  assign s_ready = !fifo_full_s;
  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = done_r;

  // Frame-end detection and the pop request: a new frame is loaded from IDLE
  // or directly at the end of the previous frame's last stop bit.
  always_comb begin
    frame_end_s = 1'b0;
    pop_s       = 1'b0;
    if (tick && (state_r == ST_STOP) && !(two_stop_r && !stop_cnt_r)) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end
    if (tick && !fifo_empty_s && ((state_r == ST_IDLE) || frame_end_s)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Zero-extend the head entry so the shared parity helper sees a fixed width.
  always_comb begin
    par_data_s                  = {UART_MAX_DATA_BITS{1'b0}};
    par_data_s[DATA_BITS-1:0]   = fifo_rdata_s;
  end

  // Latch the frame configuration and parity when a byte is taken, so cfg
  // changes mid-frame only affect the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_r   <= 1'b0;
      two_stop_r <= 1'b0;
      par_bit_r  <= 1'b0;
    end else if (pop_s) begin
      par_en_r   <= cfg_parity_en;
      two_stop_r <= cfg_two_stop;
      par_bit_r  <= uart_parity(par_data_s, cfg_parity_odd);
    end
  end

  // Transmit FSM: advances one line bit per tick and drives tx from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= {DATA_BITS{1'b0}};
      bit_cnt_r  <= 4'd0;
      stop_cnt_r <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (tick) begin
        case (state_r)
          ST_IDLE: begin
            if (!fifo_empty_s) begin
              shift_r <= fifo_rdata_s;
              tx_r    <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= ST_START;
            end
          end
          ST_START: begin
            tx_r      <= shift_r[0];
            shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= 4'd1;
            state_r   <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_cnt_r < LAST_BIT_CNT) begin
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (par_en_r) begin
              tx_r    <= par_bit_r;
              state_r <= ST_PARITY;
            end else begin
              tx_r       <= 1'b1;
              stop_cnt_r <= 1'b0;
              state_r    <= ST_STOP;
            end
          end
          ST_PARITY: begin
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= ST_STOP;
          end
          ST_STOP: begin
            if (two_stop_r && !stop_cnt_r) begin
              stop_cnt_r <= 1'b1;
            end else begin
              done_r <= 1'b1;
              if (!fifo_empty_s) begin
                // Next frame starts immediately: no idle bit between frames.
                shift_r <= fifo_rdata_s;
                tx_r    <= 1'b0;
                state_r <= ST_START;
              end else begin
                tx_r    <= 1'b1;
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            end
          end
          default: begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Self-checking bench for uart_tx_fifo_cfg: a frame-level reference model
// (bit queues) is compared against the DUT every clock, plus literal checks.
module tb_uart_tx_fifo_cfg;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       cfg_two_stop = 1'b0;
  logic       tx, tx_busy, tx_done;
  logic [2:0] fifo_level;

  logic [4:0] s_data5 = 5'h00;
  logic       s_valid5 = 1'b0;
  logic       s_ready5, tx5, tx_busy5, tx_done5;
  logic [2:0] fifo_level5;

  int n_cmp = 0;
  int n_fail = 0;
  int tick_mode = 0;   // 0: every clk, 1: random, 2: never
  int done_cnt = 0;
  int done5_cnt = 0;

  // Reference model state
  logic [7:0] m_fifo[$];
  bit         m_line[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_ticked = 1'b0;

  bit cap[$];
  bit cap5[$];

  uart_tx_fifo_cfg #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  uart_tx_fifo_cfg #(.DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut5 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .s_data(s_data5), .s_valid(s_valid5),
    .s_ready(s_ready5), .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop), .tx(tx5), .tx_busy(tx_busy5), .tx_done(tx_done5),
    .fifo_level(fifo_level5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Build a whole frame's line bits from the rules, then drive the first one.
  task automatic m_start(input logic [7:0] d);
    m_line.delete();
    m_line.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_line.push_back(d[i]);
    if (cfg_parity_en) m_line.push_back((^d) ^ cfg_parity_odd);
    m_line.push_back(1'b1);
    if (cfg_two_stop) m_line.push_back(1'b1);
    m_tx = m_line.pop_front();
    m_busy = 1'b1;
  endtask

  // Tick generator
  initial begin
    forever begin
      @(negedge clk);
      if (tick_mode == 0) tick = 1'b1;
      else if (tick_mode == 1) tick = ($urandom_range(0, 2) == 0);
      else tick = 1'b0;
    end
  end

  // Reference model: one line bit per tick; frame ends on the tick after the
  // last stop bit; FIFO pops see the pre-edge contents.
  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_fifo.delete();
        m_line.delete();
        m_tx = 1'b1;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_ticked = 1'b0;
      end else begin
        acc = s_valid && (m_fifo.size() < DEPTH);
        m_done = 1'b0;
        m_ticked = tick;
        if (tick) begin
          if (m_busy && m_line.size() != 0) begin
            m_tx = m_line.pop_front();
          end else begin
            if (m_busy) m_done = 1'b1;
            if (m_fifo.size() != 0) m_start(m_fifo.pop_front());
            else begin
              m_busy = 1'b0;
              m_tx = 1'b1;
            end
          end
        end
        if (acc) m_fifo.push_back(s_data);
      end
    end
  end

  // Compare process: every clock, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("tx", tx, m_tx);
      chk("tx_busy", tx_busy, m_busy);
      chk("tx_done", tx_done, m_done);
      chk("s_ready", s_ready, (m_fifo.size() < DEPTH));
      chk("fifo_level", fifo_level, m_fifo.size());
      if (m_ticked && tx_busy) cap.push_back(tx);
      if (m_ticked && tx_busy5) cap5.push_back(tx5);
      if (tx_done) done_cnt++;
      if (tx_done5) done5_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(negedge clk);
    s_data = d;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    cyc(3);
    while ((tx_busy || fifo_level != 3'd0) && k < budget) begin
      cyc(1);
      k++;
    end
    if (tx_busy || fifo_level != 3'd0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout busy=%0b level=%0d required idle", name, tx_busy, fifo_level);
    end
    cyc(1);
  endtask

  function automatic logic [63:0] cap_vec();
    logic [63:0] v;
    v = 64'd0;
    foreach (cap[i]) if (i < 64) v[i] = cap[i];
    return v;
  endfunction

  function automatic logic [63:0] cap5_vec();
    logic [63:0] v;
    v = 64'd0;
    foreach (cap5[i]) if (i < 64) v[i] = cap5[i];
    return v;
  endfunction

  initial begin
    int k;
    // Reset
    #1 rst_n = 1'b0;
    cyc(3);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_level", fifo_level, 3'd0);
    rst_n = 1'b1;
    cyc(3);

    // 8N1 frame of 0xA5
    tick_mode = 0;
    cap.delete(); done_cnt = 0;
    push_byte(8'hA5);
    wait_idle("8n1", 100);
    chk("8n1_len", cap.size(), 10);
    chk("8n1_bits", cap_vec(), 64'b11_0100_1010);
    chk("8n1_done", done_cnt, 1);

    // Even parity, two stop bits
    cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b1;
    cap.delete(); done_cnt = 0;
    push_byte(8'hA5);
    wait_idle("even2", 100);
    chk("even2_len", cap.size(), 12);
    chk("even2_bits", cap_vec(), 64'b1101_0100_1010);

    // Odd parity, two stop bits
    cfg_parity_odd = 1'b1;
    cap.delete(); done_cnt = 0;
    push_byte(8'hA5);
    wait_idle("odd2", 100);
    chk("odd2_len", cap.size(), 12);
    chk("odd2_bits", cap_vec(), 64'b1111_0100_1010);
    cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;

    // Fill FIFO with ticks stopped, offer a 5th byte, then drain back-to-back
    tick_mode = 2;
    cyc(2);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      s_data = 8'(i);
      s_valid = 1'b1;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("full_level", fifo_level, 3'd4);
    chk("full_s_ready", s_ready, 1'b0);
    cap.delete(); done_cnt = 0;
    tick_mode = 0;
    wait_idle("b2b", 200);
    chk("b2b_len", cap.size(), 40);
    chk("b2b_done", done_cnt, 4);
    chk("b2b_bits", cap_vec(), {24'd0, 1'b1, 8'h04, 1'b0, 1'b1, 8'h03, 1'b0,
                                1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0});

    // Parity enable toggled mid-frame affects only the next frame
    tick_mode = 2;
    cyc(2);
    push_byte(8'h3C);
    push_byte(8'h3C);
    cap.delete(); done_cnt = 0;
    tick_mode = 0;
    cyc(5);
    cfg_parity_en = 1'b1;
    wait_idle("cfgmid", 200);
    chk("cfgmid_len", cap.size(), 21);
    chk("cfgmid_done", done_cnt, 2);
    chk("cfgmid_bits", cap_vec(), {43'd0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0});
    cfg_parity_en = 1'b0;

    // Reset in the middle of the data bits
    tick_mode = 2;
    cyc(2);
    push_byte(8'hFF);
    push_byte(8'h55);
    cap.delete();
    tick_mode = 0;
    k = 0;
    while (cap.size() < 4 && k < 50) begin
      cyc(1);
      k++;
    end
    chk("midrst_reached", (cap.size() >= 4), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_level", fifo_level, 3'd0);
    cyc(3);
    rst_n = 1'b1;
    cap.delete();
    cyc(40);
    chk("postrst_bits", cap.size(), 0);
    chk("postrst_tx", tx, 1'b1);

    // DATA_BITS=5 instance
    cap5.delete(); done5_cnt = 0;
    @(negedge clk);
    s_data5 = 5'h1F;
    s_valid5 = 1'b1;
    @(negedge clk);
    s_valid5 = 1'b0;
    k = 0;
    cyc(3);
    while (tx_busy5 && k < 40) begin
      cyc(1);
      k++;
    end
    cyc(1);
    chk("db5_idle", tx_busy5, 1'b0);
    chk("db5_len", cap5.size(), 7);
    chk("db5_bits", cap5_vec(), 64'h7E);
    chk("db5_done", done5_cnt, 1);

    // Randomized traffic with random ticks and cfg changes
    tick_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      s_valid = ($urandom_range(0, 2) != 0);
      s_data = 8'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        cfg_parity_en = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        cfg_two_stop = 1'($urandom);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    tick_mode = 0;
    wait_idle("random_drain", 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
